// File: rtl/operand_issue_pkg.sv
// Shared types for the operand issue stage: datapath widths, the issue slot
// record and the issue-slot state encoding.
package Types;

  typedef logic [31:0] word;
  typedef logic [4:0]  reg_idx_t;
  typedef logic [15:0] ctrl_t;

  typedef struct packed {
    word      rs1_val;
    word      rs2_val;
    word      pc;
    word      imm;
    reg_idx_t rd;
    logic     writes_rd;
    ctrl_t    ctrl;
  } issue_t;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/operand_issue_if.sv
// Decode, register-file, execute and writeback signals of the issue stage.
// The slave modport is the issue stage itself; master is its environment.
interface operand_issue_if;
  import Types::*;

  logic     in_valid;
  logic     in_ready;
  reg_idx_t in_rs1;
  reg_idx_t in_rs2;
  reg_idx_t in_rd;
  logic     in_uses_rs1;
  logic     in_uses_rs2;
  logic     in_writes_rd;
  word      in_pc;
  word      in_imm;
  ctrl_t    in_ctrl;

  reg_idx_t rs1_sel;
  reg_idx_t rs2_sel;
  word      rs1_val;
  word      rs2_val;
  reg_idx_t rd_sel;
  word      rd_in;
  logic     rd_w;

  logic     out_valid;
  logic     out_ready;
  word      out_rs1_val;
  word      out_rs2_val;
  word      out_pc;
  word      out_imm;
  reg_idx_t out_rd;
  logic     out_writes_rd;
  ctrl_t    out_ctrl;

  logic     wb_valid;
  reg_idx_t wb_rd;
  word      wb_data;
  logic     flush;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2,
           in_writes_rd, in_pc, in_imm, in_ctrl,
           rs1_val, rs2_val, out_ready, wb_valid, wb_rd, wb_data, flush,
    output in_ready, rs1_sel, rs2_sel, rd_sel, rd_in, rd_w,
           out_valid, out_rs1_val, out_rs2_val, out_pc, out_imm, out_rd,
           out_writes_rd, out_ctrl
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2,
           in_writes_rd, in_pc, in_imm, in_ctrl,
           rs1_val, rs2_val, out_ready, wb_valid, wb_rd, wb_data, flush,
    input  in_ready, rs1_sel, rs2_sel, rd_sel, rd_in, rd_w,
           out_valid, out_rs1_val, out_rs2_val, out_pc, out_imm, out_rd,
           out_writes_rd, out_ctrl
  );

endinterface

// File: rtl/operand_issue_scoreboard.sv
// Busy-register scoreboard: one pending-write bit per architectural register,
// plus the three hazard terms for the instruction waiting at decode.
module scoreboard
  import Types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        set_en,
  input  reg_idx_t    set_idx,
  input  logic        wb_en,
  input  reg_idx_t    wb_idx,
  input  logic        kill_en,
  input  reg_idx_t    kill_idx,
  input  logic        use_rs1,
  input  reg_idx_t    rs1,
  input  logic        use_rs2,
  input  reg_idx_t    rs2,
  input  logic        use_rd,
  input  reg_idx_t    rd,
  output logic        haz_rs1,
  output logic        haz_rs2,
  output logic        haz_rd,
  output logic [31:0] busy
);

  logic [31:0] busy_next;

  // A set from a new issue overrides a clear to the same register in one cycle.
  always_comb begin
    busy_next = busy;
    if (wb_en)   busy_next[wb_idx]   = 1'b0;
    if (kill_en) busy_next[kill_idx] = 1'b0;
    if (set_en)  busy_next[set_idx]  = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  // Register file writes on negedge, so a same-cycle writeback resolves the hazard.
  assign haz_rs1 = use_rs1 && busy[rs1] && !(wb_en && (wb_idx == rs1));
  assign haz_rs2 = use_rs2 && busy[rs2] && !(wb_en && (wb_idx == rs2));
  assign haz_rd  = use_rd  && busy[rd]  && !(wb_en && (wb_idx == rd));

endmodule

// File: rtl/operand_issue.sv
// Operand issue stage: stalls on register hazards, reads operands and holds
// one issued instruction for execute, with flush and writeback tracking.
module operand_issue
  import Types::*;
(
  input  logic clk,
  input  logic rst,
  operand_issue_if.slave bus
);

  logic [0:0]  state;
  issue_t      slot;
  issue_t      captured;
  logic        out_valid;
  logic        in_ready;
  logic        fire;
  logic        haz_rs1;
  logic        haz_rs2;
  logic        haz_rd;
  logic [31:0] busy;

  assign bus.rs1_sel = bus.in_rs1;
  assign bus.rs2_sel = bus.in_rs2;
  assign bus.rd_sel  = bus.wb_rd;
  assign bus.rd_in   = bus.wb_data;
  assign bus.rd_w    = bus.wb_valid && (bus.wb_rd != '0);

  scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (fire && bus.in_writes_rd),
    .set_idx  (bus.in_rd),
    .wb_en    (bus.wb_valid),
    .wb_idx   (bus.wb_rd),
    .kill_en  (bus.flush && out_valid && slot.writes_rd),
    .kill_idx (slot.rd),
    .use_rs1  (bus.in_uses_rs1),
    .rs1      (bus.in_rs1),
    .use_rs2  (bus.in_uses_rs2),
    .rs2      (bus.in_rs2),
    .use_rd   (bus.in_writes_rd),
    .rd       (bus.in_rd),
    .haz_rs1  (haz_rs1),
    .haz_rs2  (haz_rs2),
    .haz_rd   (haz_rd),
    .busy     (busy)
  );

  assign out_valid = (state == ST_FULL);
  assign in_ready  = !rst && !bus.flush && !(haz_rs1 || haz_rs2 || haz_rd) &&
                     (!out_valid || bus.out_ready);
  assign fire      = bus.in_valid && in_ready;

  always_comb begin
    captured.rs1_val   = bus.in_uses_rs1 ? bus.rs1_val : '0;
    captured.rs2_val   = bus.in_uses_rs2 ? bus.rs2_val : '0;
    captured.pc        = bus.in_pc;
    captured.imm       = bus.in_imm;
    captured.rd        = bus.in_rd;
    captured.writes_rd = bus.in_writes_rd;
    captured.ctrl      = bus.in_ctrl;
  end

  // Flush drops the slot; otherwise a fire replaces it and a consumed slot empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      slot  <= '0;
    end else if (bus.flush) begin
      state <= ST_EMPTY;
    end else if (fire) begin
      state <= ST_FULL;
      slot  <= captured;
    end else if (bus.out_ready) begin
      state <= ST_EMPTY;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.out_rs1_val   = slot.rs1_val;
  assign bus.out_rs2_val   = slot.rs2_val;
  assign bus.out_pc        = slot.pc;
  assign bus.out_imm       = slot.imm;
  assign bus.out_rd        = slot.rd;
  assign bus.out_writes_rd = slot.writes_rd;
  assign bus.out_ctrl      = slot.ctrl;

  logic unused_busy;
  assign unused_busy = ^busy;

endmodule

// File: tb/tb_operand_issue.sv
// Self-checking bench for operand_issue: directed scenarios with literal
// expectations, then randomized traffic against a behavioural issue-slot model.
module tb_operand_issue;
  import Types::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_issue_if bus();

  operand_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file model: negedge write, combinational read.
  bit [31:0] regs [32];
  always @(negedge clk) if (bus.rd_w) regs[bus.rd_sel] <= bus.rd_in;
  assign bus.rs1_val = regs[bus.rs1_sel];
  assign bus.rs2_val = regs[bus.rs2_sel];

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_valid = 1'b0;
  word         m_rs1 = '0, m_rs2 = '0, m_pc = '0, m_imm = '0;
  reg_idx_t    m_rd = '0;
  bit          m_wr = 1'b0;
  ctrl_t       m_ctrl = '0;
  logic [31:0] m_busy = '0;
  word         drv_pc;
  word         exp_pc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input reg_idx_t r1, input reg_idx_t r2,
                               input reg_idx_t rd, input bit u1, input bit u2,
                               input bit w, input bit ordy);
    bus.in_valid     = v;
    bus.in_rs1       = r1;
    bus.in_rs2       = r2;
    bus.in_rd        = rd;
    bus.in_uses_rs1  = u1;
    bus.in_uses_rs2  = u2;
    bus.in_writes_rd = w;
    bus.in_pc        = $urandom;
    bus.in_imm       = $urandom;
    bus.in_ctrl      = 16'($urandom);
    bus.out_ready    = ordy;
    drv_pc           = bus.in_pc;
  endtask

  task automatic setSide(input bit wbv, input reg_idx_t wbr, input word wbd,
                         input bit fl, input bit r);
    bus.wb_valid = wbv;
    bus.wb_rd    = wbr;
    bus.wb_data  = wbd;
    bus.flush    = fl;
    rst          = r;
  endtask

  // A register still counts as pending unless this cycle's writeback retires it.
  function automatic bit stillBusy(input reg_idx_t idx);
    return m_busy[idx] && !(bus.wb_valid && bus.wb_rd == idx);
  endfunction

  function automatic word operand(input bit used, input reg_idx_t idx);
    if (!used) return '0;
    if (bus.wb_valid && bus.wb_rd == idx && idx != 0) return bus.wb_data;
    return regs[idx];
  endfunction

  task automatic stepCycle();
    bit          haz, exp_ready, fire;
    bit          n_valid;
    word         n_rs1, n_rs2, n_pc, n_imm;
    reg_idx_t    n_rd;
    bit          n_wr;
    ctrl_t       n_ctrl;
    logic [31:0] n_busy;
    #1;
    haz = (bus.in_uses_rs1 && stillBusy(bus.in_rs1)) ||
          (bus.in_uses_rs2 && stillBusy(bus.in_rs2)) ||
          (bus.in_writes_rd && stillBusy(bus.in_rd));
    exp_ready = !rst && !bus.flush && !haz && (!m_valid || bus.out_ready);
    fire = bus.in_valid && exp_ready;
    checkOutput("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    checkOutput("rs1_sel", 32'(bus.rs1_sel), 32'(bus.in_rs1));
    checkOutput("rs2_sel", 32'(bus.rs2_sel), 32'(bus.in_rs2));
    checkOutput("rd_sel", 32'(bus.rd_sel), 32'(bus.wb_rd));
    checkOutput("rd_in", bus.rd_in, bus.wb_data);
    checkOutput("rd_w", 32'(bus.rd_w), 32'(bus.wb_valid && bus.wb_rd != 0));

    {n_valid, n_rs1, n_rs2, n_pc, n_imm, n_rd, n_wr, n_ctrl} =
      {m_valid, m_rs1, m_rs2, m_pc, m_imm, m_rd, m_wr, m_ctrl};
    n_busy = m_busy;
    if (rst) begin
      {n_valid, n_rs1, n_rs2, n_pc, n_imm, n_rd, n_wr, n_ctrl} = '0;
      n_busy = '0;
    end else begin
      if (bus.wb_valid) n_busy[bus.wb_rd] = 1'b0;
      if (bus.flush && m_valid && m_wr) n_busy[m_rd] = 1'b0;
      if (fire && bus.in_writes_rd) n_busy[bus.in_rd] = 1'b1;
      n_busy[0] = 1'b0;
      if (bus.flush) n_valid = 1'b0;
      else if (fire) begin
        n_valid = 1'b1;
        n_rs1 = operand(bus.in_uses_rs1, bus.in_rs1);
        n_rs2 = operand(bus.in_uses_rs2, bus.in_rs2);
        n_pc = bus.in_pc; n_imm = bus.in_imm; n_rd = bus.in_rd;
        n_wr = bus.in_writes_rd; n_ctrl = bus.in_ctrl;
      end else if (bus.out_ready) n_valid = 1'b0;
    end

    @(posedge clk);
    #1;
    {m_valid, m_rs1, m_rs2, m_pc, m_imm, m_rd, m_wr, m_ctrl} =
      {n_valid, n_rs1, n_rs2, n_pc, n_imm, n_rd, n_wr, n_ctrl};
    m_busy = n_busy;
    checkOutput("out_valid", 32'(bus.out_valid), 32'(m_valid));
    checkOutput("busy", dut.u_sb.busy, m_busy);
    if (m_valid) begin
      checkOutput("out_rs1_val", bus.out_rs1_val, m_rs1);
      checkOutput("out_rs2_val", bus.out_rs2_val, m_rs2);
      checkOutput("out_pc", bus.out_pc, m_pc);
      checkOutput("out_imm", bus.out_imm, m_imm);
      checkOutput("out_rd", 32'(bus.out_rd), 32'(m_rd));
      checkOutput("out_writes_rd", 32'(bus.out_writes_rd), 32'(m_wr));
      checkOutput("out_ctrl", 32'(bus.out_ctrl), 32'(m_ctrl));
    end
  endtask

  initial begin
    setSide(1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    stepCycle();
    stepCycle();
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);

    // Preload the register file through the writeback path.
    for (int i = 1; i < 32; i++) begin
      setSide(1'b1, 5'(i), (i == 1) ? 32'd5 : (i == 2) ? 32'd7 : $urandom, 1'b0, 1'b0);
      stepCycle();
    end
    setSide(1'b0, '0, '0, 1'b0, 1'b0);

    // Independent op: add x3 <- x1, x2.
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    stepCycle();
    checkOutput("indep_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("indep_rs1", bus.out_rs1_val, 32'd5);
    checkOutput("indep_rs2", bus.out_rs2_val, 32'd7);
    checkOutput("indep_busy3", 32'(dut.u_sb.busy[3]), 32'd1);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    stepCycle();

    // RAW stall on x5 until its writeback arrives.
    applyStimulus(1'b1, '0, '0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 5'd5, '0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (2) begin
      #1;
      checkOutput("raw_stall", 32'(bus.in_ready), 32'd0);
      stepCycle();
    end
    setSide(1'b1, 5'd5, 32'h1234, 1'b0, 1'b0);
    #1;
    checkOutput("raw_release", 32'(bus.in_ready), 32'd1);
    stepCycle();
    checkOutput("raw_fwd", bus.out_rs1_val, 32'h1234);
    setSide(1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    stepCycle();

    // Backpressure: slot held for three cycles, then replaced in the release cycle.
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    exp_pc = drv_pc;
    stepCycle();
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) begin
      #1;
      checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
      stepCycle();
      checkOutput("bp_hold_pc", bus.out_pc, exp_pc);
      checkOutput("bp_hold_rd", 32'(bus.out_rd), 32'd7);
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("bp_release", 32'(bus.in_ready), 32'd1);
    stepCycle();
    checkOutput("bp_next_rd", 32'(bus.out_rd), 32'd8);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    stepCycle();

    // Flush of a full slot writing x9.
    applyStimulus(1'b1, '0, '0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    setSide(1'b0, '0, '0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("flush_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("flush_busy9", 32'(dut.u_sb.busy[9]), 32'd0);
    setSide(1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd9, '0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("flush_reissue", 32'(bus.in_ready), 32'd1);
    stepCycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    stepCycle();

    // x0 rules and reset with a full slot.
    applyStimulus(1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    stepCycle();
    checkOutput("x0_busy", 32'(dut.u_sb.busy[0]), 32'd0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    setSide(1'b1, '0, 32'hdead_beef, 1'b0, 1'b0);
    #1;
    checkOutput("x0_rd_w", 32'(bus.rd_w), 32'd0);
    stepCycle();
    setSide(1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, '0, '0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("full_busy11", 32'(dut.u_sb.busy[11]), 32'd1);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    setSide(1'b0, '0, '0, 1'b0, 1'b1);
    stepCycle();
    checkOutput("rst_full_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_full_busy", dut.u_sb.busy, 32'd0);
    checkOutput("rst_full_pc", bus.out_pc, 32'd0);
    checkOutput("rst_full_rs1", bus.out_rs1_val, 32'd0);
    setSide(1'b0, '0, '0, 1'b0, 1'b0);

    // Randomized traffic on a small register window to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
      setSide($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
      stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
